// File: rtl/div_unit.sv
// Iterative radix-2 restoring divider for DIV/DIVU.
// Returns {remainder, quotient} for the HI/LO write; EX stalls until ready_o.
module div_unit #(
  parameter int DATA_W = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  signed_div_i,
  input  logic [DATA_W-1:0]     opdata1_i,
  input  logic [DATA_W-1:0]     opdata2_i,
  input  logic                  start_i,
  input  logic                  annul_i,
  output logic [2*DATA_W-1:0]   result_o,
  output logic                  ready_o
);

  localparam int CW = $clog2(DATA_W + 1);
  localparam logic [CW-1:0] LAST = CW'(DATA_W);

  typedef enum logic [1:0] {
    S_FREE,
    S_BYZERO,
    S_ON,
    S_END
  } state_t;

  state_t              state;
  logic [CW-1:0]       cnt;
  logic [DATA_W-1:0]   dvd;
  logic [DATA_W-1:0]   dvs;
  logic [DATA_W-1:0]   rem;
  logic                neg_q;
  logic                neg_r;

  logic [DATA_W+1:0]   trial;
  logic                borrow;
  logic                sgn1;
  logic                sgn2;
  logic [DATA_W-1:0]   mag1;
  logic [DATA_W-1:0]   mag2;
  logic [DATA_W-1:0]   q_fix;
  logic [DATA_W-1:0]   r_fix;

  // Shifted remainder needs DATA_W+1 bits when the divisor exceeds 2^(W-1);
  // the extra top bit of the trial is the borrow.
  assign trial  = {1'b0, rem, dvd[DATA_W-1]} - {2'b00, dvs};
  assign borrow = trial[DATA_W+1];

  assign sgn1  = signed_div_i & opdata1_i[DATA_W-1];
  assign sgn2  = signed_div_i & opdata2_i[DATA_W-1];
  assign mag1  = sgn1 ? -opdata1_i : opdata1_i;
  assign mag2  = sgn2 ? -opdata2_i : opdata2_i;

  // dvd holds the quotient once all bits are shifted in.
  assign q_fix = neg_q ? -dvd : dvd;
  assign r_fix = neg_r ? -rem : rem;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= S_FREE;
      cnt      <= '0;
      dvd      <= '0;
      dvs      <= '0;
      rem      <= '0;
      neg_q    <= 1'b0;
      neg_r    <= 1'b0;
      result_o <= '0;
      ready_o  <= 1'b0;
    end else begin
      case (state)
        S_FREE: begin
          ready_o  <= 1'b0;
          result_o <= '0;
          if (start_i && !annul_i) begin
            if (opdata2_i == '0) begin
              state <= S_BYZERO;
            end else begin
              state <= S_ON;
              cnt   <= '0;
              dvd   <= mag1;
              dvs   <= mag2;
              rem   <= '0;
              neg_q <= sgn1 ^ sgn2;
              neg_r <= sgn1;
            end
          end
        end
        S_BYZERO: begin
          state    <= S_END;
          result_o <= '0;
          ready_o  <= 1'b1;
        end
        S_ON: begin
          if (annul_i) begin
            state    <= S_FREE;
            ready_o  <= 1'b0;
            result_o <= '0;
          end else if (cnt != LAST) begin
            if (!borrow) begin
              rem <= trial[DATA_W-1:0];
            end else begin
              rem <= {rem[DATA_W-2:0], dvd[DATA_W-1]};
            end
            dvd <= {dvd[DATA_W-2:0], ~borrow};
            cnt <= cnt + 1'b1;
          end else begin
            state    <= S_END;
            result_o <= {r_fix, q_fix};
            ready_o  <= 1'b1;
          end
        end
        S_END: begin
          if (!start_i) begin
            state    <= S_FREE;
            ready_o  <= 1'b0;
            result_o <= '0;
          end
        end
        default: begin
          state <= S_FREE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_div_unit.sv
// Randomized and directed checks of div_unit against
// a plain-arithmetic reference model.
module tb_div_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        signed_div = 1'b0;
  logic [31:0] op1 = '0;
  logic [31:0] op2 = '0;
  logic        start = 1'b0;
  logic        annul = 1'b0;
  logic [63:0] result;
  logic        ready;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  div_unit #(.DATA_W(32)) dut (
    .clk          (clk),
    .rst          (rst),
    .signed_div_i (signed_div),
    .opdata1_i    (op1),
    .opdata2_i    (op2),
    .start_i      (start),
    .annul_i      (annul),
    .result_o     (result),
    .ready_o      (ready)
  );

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] model(input bit sg,
                                        input logic [31:0] a,
                                        input logic [31:0] b);
    longint sa, sb, q, r;
    if (b == 32'd0) return 64'd0;
    if (!sg) return {a % b, a / b};
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    q  = sa / sb;
    r  = sa % sb;
    return {r[31:0], q[31:0]};
  endfunction

  task automatic run_div(input bit sg, input logic [31:0] a,
                         input logic [31:0] b, input bit toggle,
                         input logic [63:0] exp, input int exp_edges,
                         input string tag);
    int edges;
    edges = 0;
    @(negedge clk);
    signed_div = sg;
    op1 = a;
    op2 = b;
    start = 1'b1;
    while (edges < 100) begin
      @(posedge clk);
      edges++;
      @(negedge clk);
      if (ready) break;
      if (toggle) begin
        op1 = $urandom;
        op2 = $urandom;
        signed_div = 1'($urandom_range(0, 1));
      end
    end
    chk({tag, "/lat"}, 64'(edges), 64'(exp_edges));
    chk({tag, "/res"}, result, exp);
    repeat (2) @(negedge clk);
    chk({tag, "/hold_rdy"}, 64'(ready), 64'd1);
    chk({tag, "/hold_res"}, result, exp);
    start = 1'b0;
    @(negedge clk);
    chk({tag, "/drop_rdy"}, 64'(ready), 64'd0);
    chk({tag, "/drop_res"}, result, 64'd0);
  endtask

  initial begin
    int hits;
    bit sg, tg;
    logic [31:0] a, b;

    #2;
    chk("rst_rdy", 64'(ready), 64'd0);
    chk("rst_res", result, 64'd0);
    @(negedge clk);
    rst = 1'b0;

    run_div(0, 32'd100, 32'd7, 0, {32'd2, 32'hE}, 34, "divu100_7");
    run_div(1, 32'hFFFFFFF9, 32'd2, 0,
            {32'hFFFFFFFF, 32'hFFFFFFFD}, 34, "div-7_2");
    run_div(1, 32'd7, 32'hFFFFFFFE, 0,
            {32'h1, 32'hFFFFFFFD}, 34, "div7_-2");
    run_div(0, 32'd5, 32'd0, 0, 64'd0, 2, "divu_by0");
    run_div(1, 32'd5, 32'd0, 0, 64'd0, 2, "div_by0");
    run_div(1, 32'h80000000, 32'hFFFFFFFF, 0,
            {32'h0, 32'h80000000}, 34, "div_ovf");
    run_div(0, 32'hFFFFFFFF, 32'd1, 0, {32'h0, 32'hFFFFFFFF}, 34, "divu_max_1");
    run_div(0, 32'hFFFFFFFF, 32'hFFFFFFFE, 0, {32'h1, 32'h1}, 34, "divu_big");

    // Annul while ON
    @(negedge clk);
    signed_div = 1'b0;
    op1 = 32'hFFFFFFFF;
    op2 = 32'd3;
    start = 1'b1;
    repeat (10) @(posedge clk);
    @(negedge clk);
    annul = 1'b1;
    start = 1'b0;
    @(negedge clk);
    annul = 1'b0;
    hits = 0;
    repeat (40) begin
      @(negedge clk);
      if (ready) hits++;
    end
    chk("annul_no_rdy", 64'(hits), 64'd0);
    run_div(0, 32'd9, 32'd3, 0, {32'd0, 32'd3}, 34, "after_annul");

    // Annul held in FREE blocks a start
    @(negedge clk);
    op1 = 32'd8;
    op2 = 32'd2;
    start = 1'b1;
    annul = 1'b1;
    hits = 0;
    repeat (40) begin
      @(negedge clk);
      if (ready) hits++;
    end
    chk("annul_free", 64'(hits), 64'd0);
    start = 1'b0;
    annul = 1'b0;

    // Async reset mid-ON
    @(negedge clk);
    op1 = 32'd1000;
    op2 = 32'd7;
    start = 1'b1;
    repeat (15) @(posedge clk);
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("rst_on_rdy", 64'(ready), 64'd0);
    chk("rst_on_res", result, 64'd0);
    start = 1'b0;
    @(negedge clk);
    rst = 1'b0;

    // Async reset while holding a result
    @(negedge clk);
    op1 = 32'd100;
    op2 = 32'd7;
    start = 1'b1;
    hits = 0;
    while (!ready && hits < 100) begin
      @(negedge clk);
      hits++;
    end
    chk("pre_rst_res", result, {32'd2, 32'hE});
    #2 rst = 1'b1;
    #1;
    chk("rst_end_rdy", 64'(ready), 64'd0);
    chk("rst_end_res", result, 64'd0);
    start = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    run_div(0, 32'd10, 32'd3, 0, {32'd1, 32'd3}, 34, "after_rst");

    // Random operations, some with operand churn while ON
    for (int i = 0; i < 30; i++) begin
      sg = 1'($urandom_range(0, 1));
      tg = 1'($urandom_range(0, 1));
      a  = $urandom;
      case ($urandom_range(0, 7))
        0:       b = 32'd0;
        1, 2:    b = 32'($urandom_range(1, 20));
        3:       b = -32'($urandom_range(1, 20));
        default: b = $urandom;
      endcase
      if ($urandom_range(0, 3) == 0) a = a >> $urandom_range(0, 31);
      run_div(sg, a, b, tg, model(sg, a, b), (b == 32'd0) ? 2 : 34, "rand");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
